pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter and execution sequencer for the 9-bit-instruction single-issue core. It sits between instruction memory and the decoder/datapath. It starts a program on Start, advances PC one instruction per cycle, and redirects PC on taken branches. It inserts one wait cycle for each load word so the data-memory read can write back, then raises Done when control leaves the program. It also keeps a cycle count for performance reporting.

Parameters:
PC_W, 10, width of program counter and instruction-memory address
CNT_W, 16, width of the cycle counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin program at PC 0; sampled only in IDLE and DONE
Branch  input  1  decoder branch flag for the instruction at PC
Taken  input  1  ALU equality result for the current branch
Target  input  PC_W  absolute branch target from the branch lookup table
Load  input  1  decoder Load flag for the instruction at PC
ProgLen  input  PC_W  number of instructions in program; stable while running
PC  output  PC_W  instruction-memory address of the current instruction
Exec  output  1  instruction at PC is live; datapath gates RegWrite/MemWrite with it
LoadWb  output  1  data-memory read data is valid; register file captures load result
Done  output  1  program finished; level, held until next Start
CycleCount  output  CNT_W  cycles spent in RUN plus WAIT for the last or current program

Behaviour:
- FSM states: IDLE, RUN, WAIT, DONE. All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Reset (any state, including mid-program): next state IDLE. PC=0, Exec=0, LoadWb=0, Done=0, CycleCount=0.
- IDLE: Exec=0, Done=0.
  - Start=1 and ProgLen!=0: go to RUN, PC=0, CycleCount=0.
  - Start=1 and ProgLen==0: go directly to DONE; Exec is never asserted.
- RUN: Exec=1. CycleCount increments each cycle and saturates at all-ones (no wrap). Next PC (npc) is chosen in this priority:
  - Load=1: go to WAIT with PC held. Branch is ignored when Load and Branch are both high.
  - Branch=1 and Taken=1: npc=Target.
  - Otherwise npc=PC+1, computed at PC_W width.
  - Non-load path: if npc >= ProgLen (unsigned), go to DONE with PC holding its last value. Otherwise PC<=npc and stay in RUN.
  - Branch=1 with Taken=0 falls through to PC+1.
  - PC+1 overflowing PC_W wraps to 0 in arithmetic. This case is only reachable when ProgLen = 2^PC_W (unsupported; ProgLen max is 2^PC_W-1).
- WAIT: Exec=0, LoadWb=1 for exactly one cycle. CycleCount increments.
  - npc=PC+1, with the same end test: npc >= ProgLen goes to DONE, otherwise RUN with PC<=npc.
- DONE: Done=1, Exec=0, LoadWb=0. PC and CycleCount hold.
  - Start=1: go to RUN (or stay in DONE if ProgLen==0). PC=0, CycleCount=0, Done drops the same edge.
- Start asserted in RUN or WAIT is ignored.
- Latency: PC updates on the edge after the instruction is presented. A taken branch costs 1 cycle (no delay slot). A load costs 2 cycles.
- Exec is low in IDLE, WAIT and DONE. The datapath must not write state in those cycles, except the load writeback qualified by LoadWb.

Test Plan:
1. Sequential run: ProgLen=4, Start pulse, no Branch/Load → PC 0,1,2,3 with Exec=1; Done=1 on the 5th cycle after Start; CycleCount=4; PC holds 3.
2. Taken branch: ProgLen=10; at PC=2 drive Branch=1, Taken=1, Target=7 → next PC=7. Then 8, 9, then Done. Not-taken at PC=2 with Taken=0 → PC=3.
3. Load stall: ProgLen=3, Load=1 at PC=1 → PC stays 1 for 2 cycles, with Exec=1 then Exec=0/LoadWb=1; then PC=2; Done with CycleCount=4.
4. End conditions: Target=12 with ProgLen=10 → DONE immediately, PC holds the branch address. ProgLen=0 with Start → Done next cycle, Exec never high.
5. Reset mid-program: assert Reset at PC=5 in RUN → next cycle IDLE, PC=0, CycleCount=0, Done=0. Start in RUN is ignored. Start in DONE restarts at PC=0 and clears CycleCount.
6. Saturation: CNT_W=4, ProgLen=20, sequential run → CycleCount reaches 15 and holds; Done still asserts correctly.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter and execution sequencer for the 9-bit-instruction
//            single-issue core. Starts a program on Start, steps PC one
//            instruction per cycle, redirects on taken branches, inserts a
//            one-cycle writeback slot after each load, and flags Done once
//            control leaves the program. Counts RUN+WAIT cycles, saturating.
// Ports    : Clk        - system clock, rising edge
//            Reset      - synchronous, active-high reset
//            Start      - begin program at PC 0 (honoured in IDLE/DONE only)
//            Branch     - decoder branch flag for instruction at PC
//            Taken      - ALU equality result for the current branch
//            Target     - absolute branch target
//            Load       - decoder load flag for instruction at PC
//            ProgLen    - number of instructions in the program
//            PC         - instruction-memory address of current instruction
//            Exec       - instruction at PC is live
//            LoadWb     - data-memory read data valid for register writeback
//            Done       - program finished (level until next Start)
//            CycleCount - RUN+WAIT cycles of the last/current program
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Branch,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  input  logic             Load,
  input  logic [PC_W-1:0]  ProgLen,
  output logic [PC_W-1:0]  PC,
  output logic             Exec,
  output logic             LoadWb,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PC_W-1:0]  c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PC_W-1:0]  npc_d;
  logic             npc_end_d;
  logic [CNT_W-1:0] cnt_d;

  // Next-PC select. Only a RUN-state taken branch redirects; WAIT always
  // falls through to PC+1. The end test is unsigned against ProgLen.
  always_comb begin
    npc_d = pc_q + c_PC_ONE;
    if ((state_q == S_RUN) && Branch && Taken) begin
      npc_d = Target;
    end
    npc_end_d = (npc_d >= ProgLen);
  end

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : (cnt_q + c_CNT_ONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            pc_q    <= '0;
            cnt_q   <= '0;
            // An empty program finishes without ever presenting a live slot.
            state_q <= (ProgLen == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_d;
          if (Load) begin
            // PC holds so the load stays addressed during its writeback slot;
            // a coincident branch flag is ignored.
            state_q <= S_WAIT;
          end else if (npc_end_d) begin
            state_q <= S_DONE;
          end else begin
            pc_q <= npc_d;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (npc_end_d) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
            pc_q    <= npc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the registered state.
  assign PC         = pc_q;
  assign CycleCount = cnt_q;
  assign Exec       = (state_q == S_RUN);
  assign LoadWb     = (state_q == S_WAIT);
  assign Done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Two instances share the
//            inputs: one with the default counter width and one with a 4-bit
//            counter to exercise saturation. Each step drives inputs, pushes
//            the expected post-edge outputs to a scoreboard, and pops/compares
//            after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int OW   = 46;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            Branch = 1'b0;
  logic            Taken = 1'b0;
  logic            Load = 1'b0;
  logic [PC_W-1:0] Target = '0;
  logic [PC_W-1:0] ProgLen = '0;

  logic [PC_W-1:0] PC, PC_s;
  logic            Exec, LoadWb, Done, Exec_s, LoadWb_s, Done_s;
  logic [15:0]     CycleCount;
  logic [3:0]      CycleCount_s;

  pc_sequencer #(.PC_W(PC_W), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Taken(Taken),
    .Target(Target), .Load(Load), .ProgLen(ProgLen),
    .PC(PC), .Exec(Exec), .LoadWb(LoadWb), .Done(Done), .CycleCount(CycleCount)
  );

  pc_sequencer #(.PC_W(PC_W), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Taken(Taken),
    .Target(Target), .Load(Load), .ProgLen(ProgLen),
    .PC(PC_s), .Exec(Exec_s), .LoadWb(LoadWb_s), .Done(Done_s),
    .CycleCount(CycleCount_s)
  );

  always #5 Clk = ~Clk;

  // Observation vector: {pc,exec,loadwb,done,cnt16, pc,exec,loadwb,done,cnt4}
  logic [OW-1:0] w_obs;
  assign w_obs = {PC, Exec, LoadWb, Done, CycleCount,
                  PC_s, Exec_s, LoadWb_s, Done_s, CycleCount_s};

  typedef struct packed {
    logic            rst, st, br, tk, ld;
    logic [PC_W-1:0] tgt, plen;
    logic [OW-1:0]   want;
  } step_t;

  step_t         stp[$];
  logic [OW-1:0] sb[$];
  logic [OW-1:0] want;
  int            n_assert = 0;
  int            n_fail   = 0;

  function automatic logic [OW-1:0] ex(input int pc, input logic e, lw, dn, input int cnt);
    logic [9:0]  p;
    logic [15:0] c;
    logic [3:0]  cs;
    p  = pc[9:0];
    c  = cnt[15:0];
    cs = (cnt > 15) ? 4'hF : cnt[3:0];
    return {p, e, lw, dn, c, p, e, lw, dn, cs};
  endfunction

  function automatic logic [OW-1:0] run(input int pc, input int cnt);
    return ex(pc, 1'b1, 1'b0, 1'b0, cnt);
  endfunction
  function automatic logic [OW-1:0] wt(input int pc, input int cnt);
    return ex(pc, 1'b0, 1'b1, 1'b0, cnt);
  endfunction
  function automatic logic [OW-1:0] dn(input int pc, input int cnt);
    return ex(pc, 1'b0, 1'b0, 1'b1, cnt);
  endfunction
  function automatic logic [OW-1:0] idle();
    return ex(0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  task automatic add(input logic rst, st, br, tk, ld, input int tgt, plen,
                     input logic [OW-1:0] w);
    step_t x;
    x.rst = rst; x.st = st; x.br = br; x.tk = tk; x.ld = ld;
    x.tgt = tgt[PC_W-1:0]; x.plen = plen[PC_W-1:0]; x.want = w;
    stp.push_back(x);
  endtask

  task automatic drive(input step_t x);
    Reset = x.rst; Start = x.st; Branch = x.br; Taken = x.tk; Load = x.ld;
    Target = x.tgt; ProgLen = x.plen;
    sb.push_back(x.want);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    add(1, 0, 0, 0, 0, 0, 0, idle());
    add(1, 1, 0, 0, 0, 0, 4, idle());
    add(0, 0, 0, 0, 0, 0, 4, idle());
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_sequential();
    add(0, 1, 0, 0, 0, 0, 4, run(0, 0));
    for (int k = 1; k < 4; k++) add(0, 0, 0, 0, 0, 0, 4, run(k, k));
    add(0, 0, 0, 0, 0, 0, 4, dn(3, 4));
    add(0, 0, 0, 0, 0, 0, 4, dn(3, 4));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL sequential[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_branch_taken();
    add(0, 1, 0, 0, 0, 0, 10, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 10, run(1, 1));
    add(0, 0, 0, 0, 0, 0, 10, run(2, 2));
    add(0, 0, 1, 1, 0, 7, 10, run(7, 3));
    add(0, 0, 0, 0, 0, 0, 10, run(8, 4));
    add(0, 0, 0, 0, 0, 0, 10, run(9, 5));
    add(0, 0, 0, 0, 0, 0, 10, dn(9, 6));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL branch_taken[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  // Ends in RUN at PC=4; also shows Start is ignored while running.
  task automatic test_not_taken();
    add(0, 1, 0, 0, 0, 0, 10, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 10, run(1, 1));
    add(0, 0, 0, 0, 0, 0, 10, run(2, 2));
    add(0, 0, 1, 0, 0, 7, 10, run(3, 3));
    add(0, 1, 0, 0, 0, 0, 10, run(4, 4));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL not_taken[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_reset_mid();
    add(0, 0, 0, 0, 0, 0, 10, run(5, 5));
    add(1, 1, 0, 0, 0, 0, 10, idle());
    add(0, 0, 0, 0, 0, 0, 10, idle());
    add(0, 1, 0, 0, 0, 0, 2, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 2, run(1, 1));
    add(0, 0, 0, 0, 0, 0, 2, dn(1, 2));
    add(0, 1, 0, 0, 0, 0, 2, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 2, run(1, 1));
    add(0, 0, 0, 0, 0, 0, 2, dn(1, 2));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL reset_mid[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_load();
    add(1, 0, 0, 0, 0, 0, 3, idle());
    add(0, 1, 0, 0, 0, 0, 3, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 3, run(1, 1));
    add(0, 0, 1, 1, 1, 0, 3, wt(1, 2));    // branch ignored under load
    add(0, 1, 0, 0, 1, 0, 3, run(2, 3));   // inputs ignored in WAIT
    add(0, 0, 0, 0, 0, 0, 3, dn(2, 4));
    add(0, 1, 0, 0, 0, 0, 1, run(0, 0));   // load as the last instruction
    add(0, 0, 0, 0, 1, 0, 1, wt(0, 1));
    add(0, 0, 0, 0, 0, 0, 1, dn(0, 2));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL load[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_end_conditions();
    add(0, 1, 0, 0, 0, 0, 10, run(0, 0));
    add(0, 0, 0, 0, 0, 0, 10, run(1, 1));
    add(0, 0, 0, 0, 0, 0, 10, run(2, 2));
    add(0, 0, 1, 1, 0, 12, 10, dn(2, 3));
    add(0, 1, 0, 0, 0, 0, 10, run(0, 0));
    add(0, 0, 1, 1, 0, 10, 10, dn(0, 1));  // target exactly ProgLen
    add(1, 0, 0, 0, 0, 0, 0, idle());
    add(0, 1, 0, 0, 0, 0, 0, dn(0, 0));    // empty program
    add(0, 0, 0, 0, 0, 0, 0, dn(0, 0));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL end_cond[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  task automatic test_saturation();
    add(1, 0, 0, 0, 0, 0, 20, idle());
    add(0, 1, 0, 0, 0, 0, 20, run(0, 0));
    for (int k = 1; k < 20; k++) add(0, 0, 0, 0, 0, 0, 20, run(k, k));
    add(0, 0, 0, 0, 0, 0, 20, dn(19, 20));
    add(0, 0, 0, 0, 0, 0, 20, dn(19, 20));
    foreach (stp[i]) begin
      drive(stp[i]); tick();
      want = sb.pop_front(); n_assert++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL saturation[%0d]: got %h want %h", i, w_obs, want);
      end
    end
    stp.delete();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_taken();
    test_not_taken();
    test_reset_mid();
    test_load();
    test_end_conditions();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
